// File: rtl/ula_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides and registered result/flags.
// Define ULA_MC_MUL_EN to build the WIDTH-cycle shift-add multiplier for opcode 4.
module ula_mc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

`ifdef ULA_MC_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`else
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  // Single-cycle operations; opcode 4 lands in the default arm so it yields 0 when no multiplier exists.
  always_comb begin
    sum       = {1'b0, A} + {1'b0, B};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (control)
      3'd0: alu_res = A & B;
      3'd1: alu_res = A | B;
      3'd2: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      3'd3: begin
        alu_res   = A - B;
        alu_carry = (A < B);
      end
      3'd5: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      3'd6: alu_res = ~(A | B);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
`ifdef ULA_MC_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ULA_MC_MUL_EN
          if (control == 3'd4) begin
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = BUSY;
          end else
`endif
          begin
            out_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            ovf_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
`ifdef ULA_MC_MUL_EN
      // One multiplier bit per cycle; the last bit's partial sum is folded straight into the result.
      BUSY: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          out_d   = acc_nxt[WIDTH-1:0];
          zero_d  = (acc_nxt[WIDTH-1:0] == '0);
          carry_d = 1'b0;
          ovf_d   = |acc_nxt[2*WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ULA_MC_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
`ifdef ULA_MC_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ula_mc.sv
// Self-checking bench for ula_mc: directed corner cases plus random operations against an arithmetic model.
module tb_ula_mc;
  localparam int W = 8;
`ifdef ULA_MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   control = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         zero;
  logic         carry;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  ula_mc #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .control(control), .A(A), .B(B),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    control  = 3'($urandom);
    A        = W'($urandom);
    B        = W'($urandom);
    in_valid = 1'($urandom);
  endtask

  function automatic void model(input int op, input longint unsigned a, input longint unsigned b,
                                output logic [63:0] r, output logic c, output logic o);
    longint unsigned m, full;
    m = longint'(1) << W;
    r = 0; c = 1'b0; o = 1'b0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: begin full = a + b; r = full % m; c = (full >= m); end
      3: begin r = (a + m - b) % m; c = (a < b); end
      4: if (MUL_ON) begin full = a * b; r = full % m; o = (full / m) != 0; end
      5: r = (a < b) ? 1 : 0;
      6: r = (m - 1) - (a | b);
      default: r = 0;
    endcase
  endfunction

  task automatic do_op(input int op, input int a, input int b, input int hold);
    logic [63:0] er;
    logic ec, eo;
    int lat, n;
    bit rdy_bad;
    model(op, longint'(a), longint'(b), er, ec, eo);
    lat = (op == 4 && MUL_ON) ? W + 1 : 1;
    check("in_ready_idle", in_ready, 1);
    control  = 3'(op);
    A        = W'(a);
    B        = W'(b);
    in_valid = 1'b1;
    tick();
    n = 1;
    rdy_bad = 1'b0;
    scramble_inputs();
    while (out_valid !== 1'b1 && n < 4 * W) begin
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      scramble_inputs();
      tick();
      n++;
    end
    check("latency", n, lat);
    check("in_ready_busy", rdy_bad, 0);
    check("out", out, er);
    check("zero", zero, (er == 0));
    check("carry", carry, ec);
    check("overflow", overflow, eo);
    check("in_ready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      scramble_inputs();
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_out", out, er);
      check("hold_flags", {zero, carry, overflow}, {(er == 0), ec, eo});
      check("hold_ready", in_ready, 0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    check("idle_out", out, er);
    check("idle_flags", {zero, carry, overflow}, {(er == 0), ec, eo});
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_flags", {zero, carry, overflow}, 3'b100);

    do_op(2, 200, 100, 0);
    do_op(3, 5, 5, 0);
    do_op(5, 3, 9, 0);
    do_op(4, 20, 20, 0);
    do_op(4, 7, 3, 0);
    do_op(6, 8'h0F, 8'hF0, 0);
    do_op(2, 255, 1, 5);
    do_op(3, 0, 1, 1);
    do_op(4, 255, 255, 2);
    do_op(7, 9, 4, 0);

    // Reset while a multiply is in its 4th BUSY cycle (or while a result is pending in DONE).
    control  = MUL_ON ? 3'd4 : 3'd2;
    A        = 8'd20;
    B        = 8'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (MUL_ON) begin
      tick();
      tick();
      tick();
    end
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_out", out, 0);
    check("abort_flags", {zero, carry, overflow}, 3'b100);
    begin
      bit stale = 1'b0;
      for (int i = 0; i < 2 * W + 4; i++) begin
        tick();
        if (out_valid !== 1'b0) stale = 1'b1;
      end
      check("no_stale_result", stale, 0);
    end
    out_ready = 1'b0;

    for (int t = 0; t < 40; t++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ula_mc.md
ULA_MC -- requirements
Module: ula_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port control  input  3  opcode: 0 and, 1 or, 2 add, 3 sub, 4 mul, 5 slt, 6 nor, 7 reserved.
REQ-005 SHALL have ports A, B  input  WIDTH  unsigned operands.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have port out  output  WIDTH  registered result.
REQ-009 SHALL have port out_valid  output  1  out and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-011 SHALL have port zero  output  1  registered, high iff out == 0.
REQ-012 SHALL have port carry  output  1  add: carry-out; sub: borrow (A < B); else 0.
REQ-013 SHALL have port overflow  output  1  mul: upper WIDTH bits of 2*WIDTH product nonzero; else 0.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-015 SHALL, in IDLE on accept of opcode other than 4, compute result and enter DONE next cycle (latency 1).
REQ-016 SHALL, in IDLE on accept of opcode 4, latch operands, enter BUSY, perform shift-add multiply one bit per cycle, enter DONE after exactly WIDTH BUSY cycles (latency WIDTH+1).
REQ-017 SHALL compute and/or/add/sub modulo 2^WIDTH; slt = 1 if A < B unsigned else 0; nor = bitwise ~(A | B); opcode 7 yields 0.
REQ-018 SHALL hold out, zero, carry, overflow, out_valid stable in DONE until out_ready is high.
REQ-019 SHALL, in DONE with out_ready high, return to IDLE next cycle; accept of a new request occurs no earlier than that IDLE cycle (no same-cycle turnaround).
REQ-020 SHALL assert out_valid only in DONE.
REQ-021 SHALL ignore control, A, B and in_valid while in BUSY or DONE; latched operands unaffected by input changes.
REQ-022 SHALL keep out and flags at last completed values while in IDLE and BUSY.

Reset
REQ-023 SHALL, on reset high at a clock edge, force state IDLE, out = 0, zero = 1, carry = 0, overflow = 0, out_valid = 0, internal multiply registers = 0.
REQ-024 SHALL abort any in-progress multiply or pending result on reset, with no result ever delivered for it.
REQ-025 SHALL give reset priority over every handshake event in the same cycle.

Configuration
REQ-026 SHALL, with macro ULA_MC_MUL_EN defined, implement opcode 4 as in REQ-016.
REQ-027 SHALL, without ULA_MC_MUL_EN, omit BUSY state and multiplier logic; opcode 4 completes in 1 cycle with out = 0, overflow = 0.

Verification
REQ-028 SHALL cover: WIDTH=8, add A=200 B=100 -> one cycle later out_valid=1, out=44, carry=1, zero=0.
REQ-029 SHALL cover: WIDTH=8, sub A=5 B=5 -> out=0, zero=1, carry=0; slt A=3 B=9 -> out=1.
REQ-030 SHALL cover: WIDTH=8, ULA_MC_MUL_EN, mul A=20 B=20 -> out_valid exactly 9 cycles after accept, out=144, overflow=1; in_ready=0 throughout.
REQ-031 SHALL cover: out_ready held low 5 cycles in DONE -> out, flags, out_valid stable; in_ready=0; input changes ignored; release -> IDLE next cycle.
REQ-032 SHALL cover: reset asserted mid-multiply (cycle 4 of BUSY) -> next cycle IDLE, out=0, zero=1, out_valid=0; no stale result afterwards.
REQ-033 SHALL cover: ULA_MC_MUL_EN undefined, mul A=7 B=3 -> one cycle later out=0, zero=1, overflow=0; nor A=0x0F B=0xF0 -> out=0x00.
